// File: rtl/pc.sv
`default_nettype none
// ============================================================================
// Module   : pc
// Brief    : Program counter register for the instruction-fetch stage.
//            Loads the upstream next-PC value every rising clock edge.
//            Optional macro PC_WORD_ALIGN_EN forces bits [1:0] of the
//            captured value and of the reset value to zero.
// Revision : 1.0  initial release
// ============================================================================
module pc #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

`ifdef PC_WORD_ALIGN_EN
    localparam logic [WIDTH-1:0] c_WORD_MASK = {{(WIDTH-2){1'b1}}, 2'b00};
`else
    localparam logic [WIDTH-1:0] c_WORD_MASK = {WIDTH{1'b1}};
`endif

    localparam logic [WIDTH-1:0] c_RESET_Q = RESET_VALUE & c_WORD_MASK;

    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_q;

`ifdef PC_WORD_ALIGN_EN
    assign pc_d = {in[WIDTH-1:2], 2'b00};
`else
    // Pass-through keeps X/Z on in visible at out, with no masking.
    assign pc_d = in;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= c_RESET_Q;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign out = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_pc.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc
// Brief    : Directed self-checking bench for pc (32-bit default instance and
//            a 16-bit instance with RESET_VALUE = 16'h0100).
// Revision : 1.0  initial release
// ============================================================================
module tb_pc;

    logic        clk;
    logic        reset;
    logic [31:0] in32;
    logic [31:0] out32;
    logic [15:0] in16;
    logic [15:0] out16;

    int checks;
    int failures;

    pc u_dut (
        .clk   (clk),
        .reset (reset),
        .in    (in32),
        .out   (out32)
    );

    pc #(
        .WIDTH       (16),
        .RESET_VALUE (16'h0100)
    ) u_dut16 (
        .clk   (clk),
        .reset (reset),
        .in    (in16),
        .out   (out16)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [31:0] exp32(input logic [31:0] v);
`ifdef PC_WORD_ALIGN_EN
        return {v[31:2], 2'b00};
`else
        return v;
`endif
    endfunction

    function automatic logic [15:0] exp16(input logic [15:0] v);
`ifdef PC_WORD_ALIGN_EN
        return {v[15:2], 2'b00};
`else
        return v;
`endif
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        in32     = 32'h1234_5678;
        in16     = 16'hBEEF;

        // Reset asserted before any clock edge must act immediately.
        #2 reset = 1'b0;
        #1;
        check32("reset_immediate", out32, 32'h0000_0000);
        check16("reset16_immediate", out16, 16'h0100);

        repeat (3) @(posedge clk);
        #1;
        check32("reset_hold_edges", out32, 32'h0000_0000);
        check16("reset16_hold_edges", out16, 16'h0100);

        // Release away from the edge; first edge loads in.
        @(negedge clk);
        reset = 1'b1;
        #1;
        check32("release_no_effect", out32, 32'h0000_0000);
        @(posedge clk);
        #1;
        check32("basic_load", out32, exp32(32'h1234_5678));
        check16("param16_load", out16, exp16(16'hBEEF));
        #8;
        check32("basic_load_stable", out32, exp32(32'h1234_5678));

        @(negedge clk);
        in32 = 32'hABCD_EF01;
        @(posedge clk);
        #1;
        check32("seq_1", out32, exp32(32'hABCD_EF01));
        @(negedge clk);
        in32 = 32'h8765_4321;
        #1;
        check32("seq_1_hold_after_in_change", out32, exp32(32'hABCD_EF01));
        @(posedge clk);
        #1;
        check32("seq_2", out32, exp32(32'h8765_4321));

        // Asynchronous reset halfway between edges.
        @(negedge clk);
        reset = 1'b0;
        #1;
        check32("async_reset_mid", out32, 32'h0000_0000);
        check16("async_reset16_mid", out16, 16'h0100);
        @(posedge clk);
        #1;
        check32("async_reset_hold", out32, 32'h0000_0000);

        @(negedge clk);
        reset = 1'b1;
        in32  = 32'h0000_FFFC;
        @(posedge clk);
        #1;
        check32("nocomb_load", out32, 32'h0000_FFFC);
        #4;
        in32 = 32'h1111_0000;
        #1;
        check32("nocomb_hold", out32, 32'h0000_FFFC);
        @(negedge clk);
        check32("nocomb_hold_negedge", out32, 32'h0000_FFFC);
        @(posedge clk);
        #1;
        check32("nocomb_next_edge", out32, 32'h1111_0000);

        // Misaligned value exercises the low two bits.
        @(negedge clk);
        in32 = 32'h0000_0003;
        in16 = 16'h0007;
        @(posedge clk);
        #1;
        check32("low_bits", out32, exp32(32'h0000_0003));
        check16("low_bits16", out16, exp16(16'h0007));

        // Reset asserted exactly on a rising edge wins.
        in32 = 32'hFFFF_FFFF;
        @(posedge clk);
        reset = 1'b0;
        #1;
        check32("reset_on_edge", out32, 32'h0000_0000);
        check16("reset16_on_edge", out16, 16'h0100);

        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check32("reload_after_reset", out32, exp32(32'hFFFF_FFFF));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
